// File: rtl/led_hex_display.sv
// Shows an 8-bit result word as sign plus up to three decimal digits on four active-low
// seven-segment displays. A sequential double-dabble converter does the binary-to-BCD step.
module led_hex_display #(
  parameter bit SIGNED = 1'b1
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic [7:0] Value,
  output logic       Busy,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3
);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [7:0]       value_q;
  logic [7:0]       last_q;
  logic             force_reg;
  logic             primed_reg;
  logic             sign_reg;
  logic [7:0]       mag_reg;
  logic [11:0]      bcd_reg;
  logic [2:0]       count_reg;

  logic             start;
  logic             value_neg;
  logic [7:0]       abs_value;
  logic [11:0]      bcd_adj;
  logic [19:0]      shifted;
  logic [2:0][3:0]  digit;
  logic [2:0][6:0]  seg_code;
  logic [3:0][6:0]  hex_next;
  logic [3:0][6:0]  hex_reg;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // primed_reg holds off the first post-reset cycle so the forced conversion
  // sees the freshly sampled Value rather than the cleared value_q.
  assign start     = primed_reg && ((value_q != last_q) || force_reg);
  assign value_neg = SIGNED && value_q[7];
  assign abs_value = value_neg ? (~value_q + 8'd1) : value_q;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_digit
      assign digit[gi]            = bcd_reg[gi*4 +: 4];
      assign bcd_adj[gi*4 +: 4]   = (digit[gi] >= 4'd5) ? (digit[gi] + 4'd3) : digit[gi];
      assign seg_code[gi]         = seg7(digit[gi]);
    end
  endgenerate

  assign shifted = {bcd_adj, mag_reg} << 1;

  // State register
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CONVERT;
      CONVERT: if (count_reg == 3'd7) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    Busy = (state_reg != IDLE);
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      value_q    <= '0;
      last_q     <= '0;
      force_reg  <= 1'b1;
      primed_reg <= 1'b0;
      sign_reg   <= 1'b0;
      mag_reg    <= '0;
      bcd_reg    <= '0;
      count_reg  <= '0;
    end else begin
      value_q    <= Value;
      primed_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (start) begin
            last_q    <= value_q;
            force_reg <= 1'b0;
            sign_reg  <= value_neg;
            mag_reg   <= abs_value;
            bcd_reg   <= '0;
            count_reg <= '0;
          end
        end
        CONVERT: begin
          bcd_reg   <= shifted[19:8];
          mag_reg   <= shifted[7:0];
          count_reg <= count_reg + 3'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Leading-zero blanking; the ones digit is always shown.
  always_comb begin
    hex_next[0] = seg_code[0];
    hex_next[1] = ((digit[2] == 4'd0) && (digit[1] == 4'd0)) ? SEG_BLANK : seg_code[1];
    hex_next[2] = (digit[2] == 4'd0) ? SEG_BLANK : seg_code[2];
    hex_next[3] = sign_reg ? SEG_MINUS : SEG_BLANK;
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      hex_reg <= {4{SEG_BLANK}};
    end else if (state_reg == DONE) begin
      hex_reg <= hex_next;
    end
  end

  assign HEX0 = hex_reg[0];
  assign HEX1 = hex_reg[1];
  assign HEX2 = hex_reg[2];
  assign HEX3 = hex_reg[3];

endmodule
